seq_addsub: RTL
===============

Name: seq_addsub

Overview:
- Parametrised multi-cycle adder/subtractor; successor to the team's 8-bit combinational ripple adder.
- Processes DIGIT bits per clock from LSB to MSB and carries the inter-digit carry in a register.
- Offers add and subtract modes, carry/borrow-out and signed overflow.
- Valid/ready handshakes on input and output, so it drops into streaming datapaths in the TGA exercises.

Parameters:
- WIDTH, 8, operand/result width in bits.
- DIGIT, 2, bits processed per cycle. Must divide WIDTH exactly; elaboration error otherwise.
- N (localparam), WIDTH/DIGIT, number of RUN cycles.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and mode presented.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- sub  input  1  0 = A+B, 1 = A−B.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- s  output  WIDTH  sum/difference mod 2^WIDTH.
- cout  output  1  carry out. In sub mode: 1 = no borrow, i.e. A>=B unsigned.
- ovf  output  1  signed two's-complement overflow.

Behaviour:
- Reset is synchronous and active-high; one clock, clk.
- Reset values: in_ready=1, out_valid=0, s=0, cout=0, ovf=0, state=IDLE, chunk counter=0.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a into op_a, latch b^{WIDTH{sub}} into op_b, set carry=sub, clear s, set counter=0, go to RUN.
  - in_ready=0 outside IDLE. Inputs are ignored while busy.
- RUN, each cycle:
  - {c, s[k*DIGIT +: DIGIT]} = op_a chunk + op_b chunk + carry, with k = counter. carry <= c; counter++.
  - The cycle with counter==N−1 writes the MSB chunk, sets cout=c, sets ovf = (op_a[MSB]==op_b[MSB]) && (result[MSB]!=op_a[MSB]), and goes to DONE.
- Latency: out_valid rises exactly N cycles after the accepting edge. Default 4 cycles; WIDTH=8, DIGIT=8 gives 1 cycle.
- DONE:
  - out_valid=1; s, cout and ovf are stable.
  - Holds indefinitely while out_ready=0.
  - On out_ready=1: out_valid<=0, go to IDLE, in_ready=1 next cycle.
  - s/cout/ovf keep their last values until the next acceptance clears s.
  - Throughput: one operation per N+2 cycles at best.
- Boundary conditions:
  - s wraps mod 2^WIDTH.
  - Sub of equal operands gives s=0, cout=1, ovf=0.
  - Sub of 0−0 gives cout=1.
  - in_valid asserted in RUN/DONE has no effect and is not queued.
  - out_ready asserted outside DONE has no effect.
  - Reset asserted in any state, including mid-RUN, aborts the operation and restores all reset values on that edge. No result is emitted.
  - a/b/sub may change after acceptance without affecting the result.

Test Plan:
1. Reset, then add a=0, b=0 → in_ready drops; out_valid exactly 4 cycles after accept; s=0, cout=0, ovf=0.
2. Add a=4, b=8 → s=12. Add a=8'b0110, b=8'b1011 → s=17. Add a=86, b=107 → s=193, cout=0, ovf=1. Add a=200, b=100 → s=44, cout=1, ovf=0.
3. Sub a=5, b=7 → s=254, cout=0, ovf=0. Sub a=0x80, b=1 → s=0x7F, cout=1, ovf=1. Sub a=b=0x55 → s=0, cout=1.
4. Backpressure: hold out_ready=0 for 3 cycles after out_valid → s/cout/ovf/out_valid unchanged, in_ready=0, and in_valid pulses with new operands are ignored. Then out_ready=1 → out_valid=0 and in_ready=1 the next cycle.
5. Reset mid-operation: accept 32+64, assert reset on RUN cycle 2 → the next cycle shows all reset values. A new op 1+2 then returns s=3 with normal latency.
6. Parametrisation: WIDTH=16, DIGIT=4, add 0xFFFF+0x0001 → s=0, cout=1, ovf=0, latency 4. WIDTH=8, DIGIT=8 → latency 1. Compare 1000 random add/sub ops against a+b / a−b reference math.

Source files
------------

// File: rtl/seq_addsub.sv
// seq_addsub: multi-cycle adder/subtractor. Adds DIGIT bits per clock from
// LSB to MSB, keeping the inter-digit carry in a register. Subtraction is
// done as A + ~B + 1, so cout=1 in subtract mode means "no borrow".
// Valid/ready handshakes on both sides; one operation in flight at a time.
module seq_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
      $error("seq_addsub: DIGIT must be positive and divide WIDTH exactly");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic              carry;
  logic [CW-1:0]     cnt;

  logic              accept;
  logic              last;
  logic [DIGIT-1:0]  a_chunk;
  logic [DIGIT-1:0]  b_chunk;
  logic [DIGIT:0]    chunk_sum;

  // One digit of the ripple: DIGIT-bit add with carry in, carry out on top.
  function automatic logic [DIGIT:0] chunk_add(input logic [DIGIT-1:0] x,
                                               input logic [DIGIT-1:0] y,
                                               input logic             ci);
    return {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, ci};
  endfunction

  // Two's-complement overflow: like-signed operands produced an unlike-signed
  // result. op_b is already inverted for subtraction, so this covers both modes.
  function automatic logic signed_ovf(input logic sa, input logic sb,
                                      input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  assign accept    = in_valid && in_ready;
  assign last      = (cnt == CW'(N - 1));
  assign a_chunk   = op_a[cnt*DIGIT +: DIGIT];
  assign b_chunk   = op_b[cnt*DIGIT +: DIGIT];
  assign chunk_sum = chunk_add(a_chunk, b_chunk, carry);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: IDLE -> RUN on accept, RUN -> DONE after N digits,
  // DONE -> IDLE once the consumer takes the result.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs are pure decodes of the state.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Operand capture; b is pre-inverted in subtract mode so RUN only ever adds.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_a <= a;
      op_b <= b ^ {WIDTH{sub}};
    end
  end

  // Digit-serial datapath: carry chain, digit counter and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      carry <= 1'b0;
      cnt   <= '0;
      s     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            carry <= sub;
            cnt   <= '0;
            s     <= '0;
          end
        end
        RUN: begin
          s[cnt*DIGIT +: DIGIT] <= chunk_sum[DIGIT-1:0];
          carry                 <= chunk_sum[DIGIT];
          cnt                   <= last ? '0 : cnt + 1'b1;
          if (last) begin
            cout <= chunk_sum[DIGIT];
            ovf  <= signed_ovf(op_a[WIDTH-1], op_b[WIDTH-1],
                               chunk_sum[DIGIT-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
